imm_extend_arbiter: RTL
=======================

# imm_extend_arbiter

Shares one immediate-extension datapath between two requesters: requester 0 is the decode stage and requester 1 is the branch-target unit. Each cycle it picks one pending request by round-robin and extends its 16-bit immediate according to a per-request mode. The result goes into a one-deep registered response slot with valid/ready backpressure. It sits between decode/branch logic and the ALU operand mux.

## Interface
- `NREQ`, default 2: number of requesters; fixed at 2 in this revision.
- `IMM_W`, default 16: immediate input width.
- `DATA_W`, default 32: extended output width.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `NREQ`: request pending, one bit per requester.
- `req_ready` out `NREQ`: request accepted this cycle, one bit per requester.
- `req_imm` in `NREQ` x `IMM_W`: immediate field per requester.
- `req_mode` in `NREQ` x 2: extension mode per requester (type `ext_mode_t`).
- `rsp_valid` out 1: response slot holds a result.
- `rsp_ready` in 1: consumer takes the response this cycle.
- `rsp_id` out 1: which requester produced the response.
- `rsp_data` out `DATA_W`: the extended immediate.
- `grant_count` out 16: total accepted requests; wraps modulo 2^16.

## Operation
- Extension modes:
  - `EXT_SIGN` (00): `{{16{imm[15]}}, imm}`.
  - `EXT_ZERO` (01): `{16'h0, imm}`.
  - `EXT_UPPER` (10): `{imm, 16'h0}`.
  - `EXT_BRANCH` (11): sign-extend, then shift left 2; bits [1:0] = 0; upper bits are truncated to 32.
- Slot is free when `!rsp_valid || rsp_ready`.
- Arbitration is evaluated only when the slot is free:
  - If exactly one `req_valid` is set, that requester wins.
  - If both are set, the winner is the requester other than `last_grant`.
- `req_ready[i]` = slot free && winner == i. It is combinational from `req_valid`, `last_grant`, `rsp_valid` and `rsp_ready`, and is never asserted for a requester whose `req_valid` is 0.
- On acceptance (`req_valid[i] && req_ready[i]`):
  - `rsp_data` <= ext(`req_imm[i]`, `req_mode[i]`); `rsp_id` <= i; `rsp_valid` <= 1.
  - `last_grant` <= i; `grant_count` += 1.
- On `rsp_ready` with no acceptance: `rsp_valid` <= 0. `rsp_data` and `rsp_id` hold their values.
- Stalled (`rsp_valid && !rsp_ready`): no acceptance; all `req_ready` are 0; `rsp_data` and `rsp_id` stay stable.
- Requester rule: once `req_valid` is raised, the requester holds `req_valid`, `req_imm` and `req_mode` stable until accepted.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `grant_count`=0, `last_grant`=1, so requester 0 wins the first tie.
- Reset has priority over every other event. Reset mid-stall drops the pending response; no replay.
- Latency: a request accepted in cycle N appears on `rsp_*` in cycle N+1.
- Throughput: one request per cycle while `rsp_ready` is held high. Simultaneous `rsp_ready` and acceptance in the same cycle replaces the slot with no bubble.
- Fairness: with both requesters continuously valid and no backpressure, grants alternate 0,1,0,1,...
- `grant_count` 16'hFFFF + 1 -> 16'h0000, with no flag.
- `req_ready` is asserted in the acceptance cycle only.

## Structure
- Package `imm_ext_pkg`:
  - `typedef enum logic [1:0] ext_mode_t` holding the four modes.
  - Constants `IMM_W` and `DATA_W`.
  - Function `ext_imm(imm, mode)`.
- Sub-module `imm_extend_unit`: purely combinational, `imm` + `mode` -> `data`. Instantiated once, fed by a mux on the winner.
- Top-level state: response register, `last_grant` flop, 16-bit `grant_count`.

## Test plan
- Reset, then only req0 valid: imm=16'h1234, mode `EXT_SIGN` -> `req_ready[0]`=1 in cycle N; cycle N+1 shows `rsp_valid`=1, `rsp_id`=0, `rsp_data`=32'h00001234.
- All modes on imm=16'h8A12 -> `EXT_SIGN` 32'hFFFF8A12, `EXT_ZERO` 32'h00008A12, `EXT_UPPER` 32'h8A120000, `EXT_BRANCH` 32'hFFFE2848.
- Both requesters valid for 4 requests each, `rsp_ready`=1 -> `rsp_id` sequence 0,1,0,1,0,1,0,1; `grant_count`=8.
- Backpressure: `rsp_ready`=0 for 3 cycles with both requesters valid -> `req_ready`=00 throughout and `rsp_data` stable. Release `rsp_ready` -> the next grant goes to the requester other than the stalled `rsp_id`.
- Assert `reset` during a stall with `rsp_valid`=1 -> next cycle `rsp_valid`=0, `grant_count`=0, and a tie grants requester 0.
- Drive 65536 accepts -> `grant_count` wraps to 16'h0000; data path unaffected.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types, widths and the immediate-extension function.
//   ext_mode_t : immediate extension mode
//   IMM_W      : immediate width
//   DATA_W     : extended result width
//   ext_imm()  : extends one immediate according to a mode
package imm_ext_pkg;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_t;

    // Branch mode is a sign-extended word offset; bits above DATA_W are lost.
    function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                  input ext_mode_t        mode);
        logic [DATA_W-1:0] sx;
        sx = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        case (mode)
            EXT_SIGN:   ext_imm = sx;
            EXT_ZERO:   ext_imm = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_UPPER:  ext_imm = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_BRANCH: ext_imm = {sx[DATA_W-3:0], 2'b00};
            default:    ext_imm = sx;
        endcase
    endfunction

endpackage

// File: rtl/imm_extend_unit.sv
// Combinational immediate extender.
//   imm  : IMM_W-bit immediate
//   mode : extension mode
//   data : DATA_W-bit extended result
module imm_extend_unit
    import imm_ext_pkg::*;
(
    input  logic [IMM_W-1:0]  imm,
    input  ext_mode_t         mode,
    output logic [DATA_W-1:0] data
);

    assign data = ext_imm(imm, mode);

endmodule

// File: rtl/imm_extend_arbiter.sv
// Two-requester round-robin arbiter in front of one shared immediate extender,
// with a one-deep registered response slot under valid/ready backpressure.
//   clk, reset  : clock, synchronous active-high reset
//   req_valid   : per-requester request pending
//   req_ready   : per-requester accept this cycle (combinational)
//   req_imm     : per-requester immediate
//   req_mode    : per-requester extension mode
//   rsp_valid   : response slot occupied
//   rsp_ready   : consumer takes the response
//   rsp_id      : requester that produced the response
//   rsp_data    : extended immediate
//   grant_count : accepted requests, wraps modulo 2^16
module imm_extend_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned IMM_W  = imm_ext_pkg::IMM_W,
    parameter int unsigned DATA_W = imm_ext_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][IMM_W-1:0]  req_imm,
    input  logic [NREQ-1:0][1:0]        req_mode,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [15:0]                 grant_count
);

    import imm_ext_pkg::ext_mode_t;

    logic              r_last_grant;
    logic              w_free;
    logic              w_win;
    logic              w_accept;
    logic [DATA_W-1:0] w_ext_data;

    // Slot can take a new result when empty or being drained this cycle.
    assign w_free = !rsp_valid || rsp_ready;

    // Requester 1 wins when it is alone, or on a tie when 0 was granted last.
    assign w_win    = req_valid[1] && (!req_valid[0] || !r_last_grant);
    assign w_accept = w_free && (|req_valid);

    assign req_ready[0] = w_free && req_valid[0] && !w_win;
    assign req_ready[1] = w_free && w_win;

    imm_extend_unit u_ext (
        .imm  (req_imm[w_win]),
        .mode (ext_mode_t'(req_mode[w_win])),
        .data (w_ext_data)
    );

    // Response slot, round-robin pointer and grant counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_id       <= 1'b0;
            grant_count  <= 16'h0000;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            rsp_valid    <= 1'b1;
            rsp_data     <= w_ext_data;
            rsp_id       <= w_win;
            grant_count  <= grant_count + 16'd1;
            r_last_grant <= w_win;
        end else if (rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end

endmodule
